// File: rtl/ysyx_25060170_wb_arb.sv
// Write-back arbiter: shares the single regfile write port between EXU and LSU
// with round-robin priority on contention and a registered retire counter.
module ysyx_25060170_wb_arb #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exu_valid_i,
  input  logic [4:0]       exu_rd_i,
  input  logic [31:0]      exu_data_i,
  output logic             exu_ready_o,
  input  logic             lsu_valid_i,
  input  logic [4:0]       lsu_rd_i,
  input  logic [31:0]      lsu_data_i,
  output logic             lsu_ready_o,
  output logic             reg_write_en_o,
  output logic [4:0]       reg_write_addr_o,
  output logic [31:0]      reg_write_data_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  localparam int unsigned RD_W   = 5;
  localparam int unsigned DATA_W = 32;
  localparam logic        GRANT_EXU = 1'b0;
  localparam logic        GRANT_LSU = 1'b1;

  logic              last_grant;
  logic              exu_hs;
  logic              lsu_hs;
  logic              any_hs;
  logic [RD_W-1:0]   win_rd;
  logic [DATA_W-1:0] win_data;

  // A source is ready when the other is idle or the other won last time.
  always_comb begin
    exu_ready_o = 1'b0;
    lsu_ready_o = 1'b0;
    if (!rst) begin
      exu_ready_o = !lsu_valid_i || (last_grant == GRANT_LSU);
      lsu_ready_o = !exu_valid_i || (last_grant == GRANT_EXU);
    end
  end

  always_comb begin
    exu_hs   = exu_valid_i && exu_ready_o;
    lsu_hs   = lsu_valid_i && lsu_ready_o;
    any_hs   = exu_hs || lsu_hs;
    win_rd   = lsu_hs ? lsu_rd_i   : exu_rd_i;
    win_data = lsu_hs ? lsu_data_i : exu_data_i;
  end

  // Write-back register stage; a handshake to x0 retires without writing.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant       <= GRANT_LSU;
      reg_write_en_o   <= 1'b0;
      reg_write_addr_o <= '0;
      reg_write_data_o <= '0;
      retire_o         <= 1'b0;
      retire_cnt_o     <= '0;
    end else begin
      reg_write_en_o <= any_hs && (win_rd != RD_W'(0));
      retire_o       <= any_hs;
      if (any_hs) begin
        reg_write_addr_o <= win_rd;
        reg_write_data_o <= win_data;
        retire_cnt_o     <= retire_cnt_o + CNT_W'(1);
        last_grant       <= lsu_hs ? GRANT_LSU : GRANT_EXU;
      end
    end
  end

endmodule

// File: doc/ysyx_25060170_wb_arb.md
YSYX_25060170_WB_ARB -- requirements
Module: ysyx_25060170_wb_arb

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 32, width of the retire counter.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, declared first:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
REQ-003 The block SHALL have the following ports:
- exu_valid_i  input  1  EXU write-back request
- exu_rd_i  input  5  EXU destination register
- exu_data_i  input  32  EXU ALU result
- exu_ready_o  output  1  EXU request accepted this cycle
- lsu_valid_i  input  1  LSU write-back request
- lsu_rd_i  input  5  LSU destination register
- lsu_data_i  input  32  LSU load data
- lsu_ready_o  output  1  LSU request accepted this cycle
- reg_write_en_o  output  1  regfile write enable, registered
- reg_write_addr_o  output  5  regfile write address, registered
- reg_write_data_o  output  32  regfile write data, registered
- retire_o  output  1  one-cycle pulse per accepted request, registered
- retire_cnt_o  output  CNT_W  accepted-request count, registered

Function
REQ-004 The block SHALL share the single regfile write port between EXU and LSU, granting at most one requester per cycle.
REQ-005 Each ready SHALL be combinational from the valid inputs and the priority state, and SHALL NOT depend on its own valid.
REQ-006 A handshake SHALL occur on a source when its valid=1 and its ready=1 in the same cycle.
REQ-007 A requester with valid=1 and ready=0 SHALL hold valid, rd and data stable until its handshake.
REQ-008 Priority state SHALL be a 1-bit register last_grant (EXU=0, LSU=1).
REQ-009 Arbitration SHALL be:
- only one valid: that source granted
- both valid: the source not equal to last_grant granted
- none valid: no grant
REQ-010 last_grant SHALL update to the granted source on every handshake and SHALL hold otherwise.
REQ-011 With both sources continuously valid, grants SHALL alternate every cycle, so no source waits more than 1 cycle.
REQ-012 The cycle after a handshake, outputs SHALL be:
- reg_write_en_o = 1 if the granted rd != 0, else 0
- reg_write_addr_o = granted rd
- reg_write_data_o = granted data
REQ-013 Write-back latency SHALL be exactly 1 cycle from handshake to reg_write_en_o.
REQ-014 reg_write_en_o SHALL be high for exactly one cycle per handshake.
REQ-015 In cycles with no handshake:
- reg_write_en_o = 0
- reg_write_addr_o and reg_write_data_o hold their previous values
REQ-016 A handshake with rd=0 SHALL produce reg_write_en_o=0, retire_o=1 and increment retire_cnt_o; data SHALL be discarded.
REQ-017 retire_o SHALL pulse 1 the cycle after every handshake, independent of rd.
REQ-018 retire_cnt_o SHALL increment by 1 per handshake, modulo 2^CNT_W, wrapping from all-ones to 0.
REQ-019 When both sources are valid with the same nonzero rd, writes SHALL occur on consecutive cycles in grant order, so the later-granted value persists; ordering is otherwise the pipeline's responsibility.

Reset
REQ-020 While rst=1 the block SHALL drive:
- exu_ready_o=0 and lsu_ready_o=0 (no handshake)
- reg_write_en_o=0, reg_write_addr_o=0, reg_write_data_o=0
- retire_o=0, retire_cnt_o=0
- last_grant=1, so EXU wins the first contention
REQ-021 Asserting rst in the same cycle as a handshake SHALL discard that request: no write and no count in the following cycle.
REQ-022 In the first cycle after rst deasserts, normal arbitration SHALL apply.

Verification
REQ-023 Single EXU: exu_valid_i=1, rd=5, data=0x0000_00FF for 1 cycle -> next cycle reg_write_en_o=1, addr=5, data=0xFF, retire_o=1, retire_cnt_o=1.
REQ-024 Contention after reset: both valid, EXU rd=3 data=0x11, LSU rd=4 data=0x22, held -> cycle 1 EXU granted (addr 3, 0x11); cycle 2 LSU granted (addr 4, 0x22); lsu_ready_o=0 in cycle 1.
REQ-025 Sustained contention for 8 cycles -> grants alternate EXU,LSU,... and retire_cnt_o=8 with no idle write cycle.
REQ-026 x0 write: LSU rd=0 data=0xDEADBEEF -> reg_write_en_o=0, retire_o=1, counter increments.
REQ-027 Wrap and reset: CNT_W=4, 16 handshakes -> retire_cnt_o=0; then rst asserted during a handshake -> no write next cycle and all outputs 0.
